// File: rtl/ascon_pack.sv
// Shared constants, state encoding and padding helper for the Ascon block packer.
package ascon_pack;

  localparam int unsigned WORD_WIDTH      = 32;
  localparam int unsigned WORDS_PER_BLOCK = 4;
  localparam int unsigned BLOCK_WIDTH     = WORD_WIDTH * WORDS_PER_BLOCK;
  localparam int unsigned BLOCK_BYTES     = BLOCK_WIDTH / 8;
  localparam logic [7:0]  PAD_BYTE        = 8'h01;

  typedef enum logic [1:0] {
    FILL,
    EMIT,
    EMIT_PAD
  } packer_state_t;

  // Byte n becomes the pad marker; every byte above it is zeroed.
  function automatic logic [BLOCK_WIDTH-1:0] pad_block(input logic [BLOCK_WIDTH-1:0] blk,
                                                       input logic [4:0]             n);
    logic [BLOCK_WIDTH-1:0] r;
    r = blk;
    for (int i = 0; i < int'(BLOCK_BYTES); i++) begin
      if (5'(i) == n) begin
        r[8*i +: 8] = PAD_BYTE;
      end else if (5'(i) > n) begin
        r[8*i +: 8] = 8'h00;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ascon_block_packer.sv
// Packs 32-bit bus words into 128-bit little-endian rate blocks and applies Ascon padding
// to the final block of each stream, with a separate pad-only block on exact multiples.
module ascon_block_packer #(
  parameter int unsigned WORD_WIDTH  = ascon_pack::WORD_WIDTH,
  parameter int unsigned BLOCK_WIDTH = ascon_pack::BLOCK_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear_i,
  input  logic                   word_valid_i,
  output logic                   word_ready_o,
  input  logic [WORD_WIDTH-1:0]  word_i,
  input  logic                   word_last_i,
  input  logic [2:0]             word_bytes_i,
  output logic                   blk_valid_o,
  input  logic                   blk_ready_i,
  output logic [BLOCK_WIDTH-1:0] blk_data_o,
  output logic                   blk_last_o,
  output logic [4:0]             blk_bytes_o
);
  import ascon_pack::*;

  packer_state_t          state_q, state_d;
  logic [2:0]             word_cnt_q, word_cnt_d;
  logic                   pad_pending_q, pad_pending_d;
  logic [BLOCK_WIDTH-1:0] block_q, block_d;
  logic                   last_q, last_d;
  logic [4:0]             bytes_q, bytes_d;

  logic [2:0]            bytes_eff;
  logic [WORD_WIDTH-1:0] word_masked;
  logic [4:0]            n;
  logic                  accept;

  assign word_ready_o = (state_q == FILL);
  assign blk_valid_o  = (state_q != FILL);
  assign blk_data_o   = block_q;
  assign blk_last_o   = last_q;
  assign blk_bytes_o  = bytes_q;

  assign accept = word_valid_i & word_ready_o;

  always_comb begin
    // Non-last words always count as full; oversized counts on a last word clamp to 4.
    bytes_eff = 3'd4;
    if (word_last_i) begin
      bytes_eff = (word_bytes_i > 3'd4) ? 3'd4 : word_bytes_i;
    end
    word_masked = word_i;
    for (int j = 0; j < WORD_WIDTH / 8; j++) begin
      if (3'(j) >= bytes_eff) begin
        word_masked[8*j +: 8] = 8'h00;
      end
    end
    n = 5'({word_cnt_q[1:0], 2'b00}) + 5'(bytes_eff);
  end

  always_comb begin
    state_d       = state_q;
    word_cnt_d    = word_cnt_q;
    pad_pending_d = pad_pending_q;
    block_d       = block_q;
    last_d        = last_q;
    bytes_d       = bytes_q;

    if (clear_i) begin
      state_d       = FILL;
      word_cnt_d    = 3'd0;
      pad_pending_d = 1'b0;
      block_d       = '0;
      last_d        = 1'b0;
      bytes_d       = 5'd0;
    end else begin
      unique case (state_q)
        FILL: begin
          if (accept) begin
            for (int k = 0; k < int'(WORDS_PER_BLOCK); k++) begin
              if (word_cnt_q[1:0] == 2'(k)) begin
                block_d[k*WORD_WIDTH +: WORD_WIDTH] = word_masked;
              end
            end
            word_cnt_d = word_cnt_q + 3'd1;
            if (word_last_i || word_cnt_q == 3'd3) begin
              state_d = EMIT;
              last_d  = 1'b0;
              bytes_d = 5'd16;
              if (word_last_i && n < 5'd16) begin
                block_d = pad_block(block_d, n);
                last_d  = 1'b1;
                bytes_d = n;
              end else if (word_last_i) begin
                pad_pending_d = 1'b1;
              end
            end
          end
        end
        EMIT: begin
          if (blk_ready_i) begin
            if (pad_pending_q) begin
              state_d       = EMIT_PAD;
              block_d       = BLOCK_WIDTH'(PAD_BYTE);
              last_d        = 1'b1;
              bytes_d       = 5'd0;
              pad_pending_d = 1'b0;
            end else begin
              state_d    = FILL;
              word_cnt_d = 3'd0;
              block_d    = '0;
              last_d     = 1'b0;
              bytes_d    = 5'd0;
            end
          end
        end
        EMIT_PAD: begin
          if (blk_ready_i) begin
            state_d    = FILL;
            word_cnt_d = 3'd0;
            block_d    = '0;
            last_d     = 1'b0;
            bytes_d    = 5'd0;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FILL;
      word_cnt_q    <= 3'd0;
      pad_pending_q <= 1'b0;
      block_q       <= '0;
      last_q        <= 1'b0;
      bytes_q       <= 5'd0;
    end else begin
      state_q       <= state_d;
      word_cnt_q    <= word_cnt_d;
      pad_pending_q <= pad_pending_d;
      block_q       <= block_d;
      last_q        <= last_d;
      bytes_q       <= bytes_d;
    end
  end

endmodule

// File: doc/ascon_block_packer.md
Name: ascon_block_packer

Overview:
- Upstream neighbour of the AEAD128 block input register. Collects 32-bit bus words into one 128-bit rate block and applies Ascon padding on the final block of each AD or message stream.
- Presents each block on a valid/ready interface. The integrator ties `blk_valid_o & blk_ready_i` to the input register's enable and `blk_data_o` to its data input.
- Byte order is little-endian throughout.
  - Word k occupies block bits [32k+31:32k].
  - Byte j of a word occupies word bits [8j+7:8j].

Parameters:
- WORD_WIDTH, 32, bus word width; fixed, 4 words per block.
- BLOCK_WIDTH, 128 (from ascon_pack), rate block width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- clear_i  in  1  synchronous flush; abandons the current partial block or emission
- word_valid_i  in  1  input word valid
- word_ready_o  out  1  packer can accept a word
- word_i  in  WORD_WIDTH  input word
- word_last_i  in  1  final word of the stream
- word_bytes_i  in  3  valid bytes in the last word, 0..4; ignored (treated as 4) when word_last_i=0
- blk_valid_o  out  1  block available
- blk_ready_i  in  1  downstream accepts the block
- blk_data_o  out  BLOCK_WIDTH  block, padded when final
- blk_last_o  out  1  final block of the stream
- blk_bytes_o  out  5  payload bytes in the block, 0..16

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=FILL, word_cnt=0, pad_pending=0
  - blk_valid_o=0, blk_data_o=0, blk_last_o=0, blk_bytes_o=0
  - word_ready_o=1 after reset release
- States are FILL, EMIT and EMIT_PAD. word_ready_o=1 only in FILL; blk_valid_o=1 only in EMIT and EMIT_PAD.
- FILL, word accepted (word_valid_i & word_ready_o):
  - The word is written to lane word_cnt. Bytes at positions ≥ word_bytes_i are zeroed when the word is last.
  - word_cnt increments.
  - Running byte count n = 4*word_cnt + (last ? word_bytes_i : 4).
- FILL → EMIT on acceptance of word 3, or of a last word.
  - If last and n<16: byte n := 0x01, bytes above n are 0, blk_last_o=1, blk_bytes_o=n.
  - If last and n=16: blk_last_o=0, blk_bytes_o=16, pad_pending=1.
  - Non-last full block: blk_last_o=0, blk_bytes_o=16.
  - Unwritten lanes are 0.
- Latency: blk_valid_o rises the cycle after the handshake of the block's final word.
- EMIT:
  - Outputs are held stable while blk_ready_i=0.
  - On blk_ready_i with pad_pending=1 → EMIT_PAD. blk_data_o=128'h01, blk_last_o=1, blk_bytes_o=0, pad_pending clears.
  - On blk_ready_i otherwise → FILL. word_cnt=0, block register cleared to 0.
- EMIT_PAD: on blk_ready_i → FILL, same clearing.
- Empty stream: a last word with word_bytes_i=0 at word_cnt=0 gives blk_data_o=128'h01, blk_bytes_o=0, blk_last_o=1.
- No word is accepted during EMIT or EMIT_PAD; no bypass or overlap.
- word_bytes_i>4 on a last word is illegal and clamped to 4.
- clear_i has priority over all handshakes that cycle. It forces the full reset state on the next edge and never produces a partial block.
- Reset mid-emit drops the pending block; blk_valid_o goes to 0 immediately.

Decomposition:
- ascon_pack holds:
  - WORD_WIDTH, WORDS_PER_BLOCK=4, PAD_BYTE=8'h01
  - packer_state_t enum {FILL, EMIT, EMIT_PAD}
  - function pad_block(block, n), returning the block with byte n set to 0x01 and higher bytes zeroed
- No sub-module is needed. One always_ff holds state, counter and block register; one always_comb computes next-state and lane masking.

Test Plan:
- Full block: words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C, no last → one block 128'h0F0E0D0C0B0A090807060504_03020100, bytes=16, last=0, valid one cycle after the 4th handshake.
- Partial block: 0x03020100, then 0xFFFF0504 with last and bytes=2 → 128'h0000000000000000_00010504_03020100, bytes=6, last=1.
- Exact multiple: 4 words with the 4th last and bytes=4 → data block (last=0, bytes=16), then 128'h01 (last=1, bytes=0). word_ready_o stays 0 until the pad block is accepted.
- Empty stream and backpressure:
  - A last word with bytes=0 → 128'h01, last=1.
  - Holding blk_ready_i=0 for 5 cycles keeps data, last and bytes constant and word_ready_o=0.
- clear_i and reset:
  - Assert clear_i after 2 words → no block emitted; the next 4 words form a clean block with no stale lanes.
  - Assert rst_n low during EMIT → blk_valid_o=0 asynchronously, all outputs 0.
